// File: rtl/nf_dm_pkg.sv
// nanoFOX data-memory responder: shared types and helpers.
// State enum, access-size codes and the byte-enable/misalign decoder.
package nf_dm_pkg;

    typedef enum logic [1:0] {
        DM_IDLE,
        DM_BUSY,
        DM_RESP
    } dm_state_t;

    localparam logic [1:0] DM_SZ_B = 2'd0;
    localparam logic [1:0] DM_SZ_H = 2'd1;
    localparam logic [1:0] DM_SZ_W = 2'd2;

    typedef struct packed {
        logic [3:0] be;
        logic       mis;
    } dm_be_t;

    // Size code 3 falls into the word branch.
    // A misaligned access gets no byte enables at all.
    function automatic dm_be_t dm_be(
        input logic [1:0] sz,
        input logic [1:0] a
    );
        dm_be_t r;
        r.be  = 4'b1111;
        r.mis = 1'b0;
        case (sz)
            DM_SZ_B: r.be = 4'b0001 << a;
            DM_SZ_H: begin
                r.be  = 4'b0011 << {a[1], 1'b0};
                r.mis = a[0];
            end
            default: begin
                r.be  = 4'b1111;
                r.mis = |a;
            end
        endcase
        if (r.mis)
            r.be = 4'b0000;
        return r;
    endfunction

endpackage

// File: rtl/nf_dm_ram.sv
// Single-port DEPTH x 32 data RAM, per-byte write enables, registered read.
// Ports: clk, resetn, re, we[3:0], addr, wd, rd (read register only is reset).
module nf_dm_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          re,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wd,
    output logic [31:0]   rd
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i])
                mem[addr][8*i +: 8] <= wd[8*i +: 8];
        end
    end

    // Output holds between loads; stores leave it untouched.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            rd <= '0;
        else if (re)
            rd <= mem[addr];
    end

endmodule

// File: rtl/nf_dm_resp.sv
// MEM-stage data-memory responder: latch request, wait, access RAM, ack.
// Ports: clk, resetn, req_dm/we_dm/addr_dm/wd_dm/size_dm in; rd_dm, req_ack_dm, misalign_dm out.
module nf_dm_resp
    import nf_dm_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_dm,
    input  logic        we_dm,
    input  logic [31:0] addr_dm,
    input  logic [31:0] wd_dm,
    input  logic [1:0]  size_dm,
    output logic [31:0] rd_dm,
    output logic        req_ack_dm,
    output logic        misalign_dm
);

    localparam int AW = $clog2(DEPTH);

    dm_state_t     state;
    dm_state_t     nxt;
    logic [3:0]    cnt;
    logic [AW+1:0] a_q;
    logic [31:0]   wd_q;
    logic          we_q;
    logic [1:0]    sz_q;
    logic          ack_q;
    logic          mis_q;

    dm_be_t        bi;
    logic          access;
    logic [3:0]    ram_we;
    logic          ram_re;
    logic [31:0]   wd_sh;

    // Upper address bits alias away.
    logic unused_addr;
    assign unused_addr = &{1'b0, addr_dm[31:AW+2]};

    always_comb begin
        nxt = state;
        unique case (state)
            DM_IDLE: if (req_dm) nxt = DM_BUSY;
            DM_BUSY: if (cnt == 4'd0) nxt = DM_RESP;
            DM_RESP: nxt = DM_IDLE;
            default: nxt = DM_IDLE;
        endcase
    end

    assign access = (state == DM_BUSY) && (cnt == 4'd0);
    assign bi     = dm_be(sz_q, a_q[1:0]);

    always_comb begin
        wd_sh = wd_q;
        case (sz_q)
            DM_SZ_B: wd_sh = 32'(wd_q[7:0]) << {a_q[1:0], 3'b000};
            DM_SZ_H: wd_sh = 32'(wd_q[15:0]) << {a_q[1], 4'b0000};
            default: wd_sh = wd_q;
        endcase
    end

    assign ram_we = (access && we_q) ? bi.be : 4'b0000;
    assign ram_re = access && !we_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= DM_IDLE;
            cnt   <= '0;
            a_q   <= '0;
            wd_q  <= '0;
            we_q  <= 1'b0;
            sz_q  <= '0;
            ack_q <= 1'b0;
            mis_q <= 1'b0;
        end else begin
            state <= nxt;
            if (state == DM_IDLE && req_dm) begin
                a_q  <= addr_dm[AW+1:0];
                wd_q <= wd_dm;
                we_q <= we_dm;
                sz_q <= size_dm;
                cnt  <= 4'(WAIT_CYCLES);
            end else if (state == DM_BUSY && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            // Registered so the pulses are clean and exactly cover RESP.
            ack_q <= access;
            mis_q <= access && bi.mis;
        end
    end

    assign req_ack_dm  = ack_q;
    assign misalign_dm = mis_q;

    nf_dm_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk    (clk),
        .resetn (resetn),
        .re     (ram_re),
        .we     (ram_we),
        .addr   (a_q[AW+1:2]),
        .wd     (wd_sh),
        .rd     (rd_dm)
    );

endmodule

// File: tb/tb_nf_dm_resp.sv
// Scoreboard bench for nf_dm_resp against a byte-array reference model.
// Ports: none (drives clk, resetn and the request bundle of the DUT).
module tb_nf_dm_resp;
    import nf_dm_pkg::*;

    localparam int DEPTH = 64;
    localparam int WC    = 2;
    localparam int NB    = DEPTH * 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_dm = 1'b0;
    logic        we_dm = 1'b0;
    logic [31:0] addr_dm = '0;
    logic [31:0] wd_dm = '0;
    logic [1:0]  size_dm = '0;
    logic [31:0] rd_dm;
    logic        req_ack_dm;
    logic        misalign_dm;

    nf_dm_resp #(
        .DEPTH       (DEPTH),
        .WAIT_CYCLES (WC)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .req_dm      (req_dm),
        .we_dm       (we_dm),
        .addr_dm     (addr_dm),
        .wd_dm       (wd_dm),
        .size_dm     (size_dm),
        .rd_dm       (rd_dm),
        .req_ack_dm  (req_ack_dm),
        .misalign_dm (misalign_dm)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] rd;
        logic        mis;
        int          cyc;
        string       nm;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  mem_b [NB];
    logic [31:0] last_rd = '0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: compare every acknowledge against the scoreboard head.
    always @(negedge clk) begin
        if (resetn && misalign_dm && !req_ack_dm)
            chk("mis_without_ack", 32'(misalign_dm), 32'd0);
        if (resetn && req_ack_dm) begin
            if (sb.size() == 0) begin
                chk("spurious_ack", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.nm, "_rd"}, rd_dm, e.rd);
                chk({e.nm, "_mis"}, 32'(misalign_dm), 32'(e.mis));
                chk({e.nm, "_lat"}, 32'(cyc), 32'(e.cyc));
            end
        end
    end

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    task automatic do_req(input logic we, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [1:0] sz,
                          input string nm);
        exp_t e;
        int   n;
        int   base;
        int   wb;
        bit   got;
        n    = nbytes(sz);
        base = int'(addr % NB);
        wb   = base - (base % 4);
        e.mis = (addr % n) != 0;
        if (we && !e.mis) begin
            for (int i = 0; i < n; i++)
                mem_b[base + i] = wd[8*i +: 8];
        end
        if (!we)
            last_rd = {mem_b[wb+3], mem_b[wb+2], mem_b[wb+1], mem_b[wb]};
        e.rd = last_rd;
        e.nm = nm;
        @(posedge clk);
        #1;
        req_dm  = 1'b1;
        we_dm   = we;
        addr_dm = addr;
        wd_dm   = wd;
        size_dm = sz;
        e.cyc   = cyc + WC + 2;
        sb.push_back(e);
        got = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (req_ack_dm) begin
                got = 1;
                break;
            end
        end
        req_dm = 1'b0;
        if (!got) begin
            chk({nm, "_timeout"}, 32'd0, 32'd1);
            void'(sb.pop_front());
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst_ack", 32'(req_ack_dm), 32'd0);
            chk("rst_rd", rd_dm, 32'd0);
            chk("rst_state", 32'(dut.state == DM_IDLE), 32'd1);
        end

        for (int w = 0; w < DEPTH; w++)
            do_req(1'b1, 32'(w * 4), $urandom, DM_SZ_W, "init");

        do_req(1'b1, 32'h10, 32'hDEADBEEF, DM_SZ_W, "st_w");
        do_req(1'b0, 32'h10, 32'h0, DM_SZ_W, "ld_w");
        chk("ld_w_const", last_rd, 32'hDEADBEEF);

        do_req(1'b1, 32'h10, 32'h0, DM_SZ_W, "clr");
        do_req(1'b1, 32'h11, 32'hFFFF_FFAA, DM_SZ_B, "st_b");
        do_req(1'b1, 32'h12, 32'hFFFF_1234, DM_SZ_H, "st_h");
        do_req(1'b0, 32'h10, 32'h0, DM_SZ_W, "ld_bh");
        chk("ld_bh_const", last_rd, 32'h1234AA00);

        do_req(1'b1, 32'h12, 32'hFFFFFFFF, DM_SZ_W, "st_mis");
        do_req(1'b0, 32'h10, 32'h0, DM_SZ_W, "ld_after_mis");
        do_req(1'b0, 32'h13, 32'h0, DM_SZ_H, "ld_mis");

        do_req(1'b0, 32'h0, 32'h0, DM_SZ_W, "ld_0");
        do_req(1'b0, 32'(4 * DEPTH), 32'h0, DM_SZ_W, "ld_alias");

        // Store aborted by reset while still in BUSY.
        do_req(1'b0, 32'h10, 32'h0, DM_SZ_W, "ld_pre_rst");
        @(posedge clk);
        #1;
        req_dm  = 1'b1;
        we_dm   = 1'b1;
        addr_dm = 32'h20;
        wd_dm   = 32'h55AA_55AA;
        size_dm = DM_SZ_W;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        chk("arst_ack", 32'(req_ack_dm), 32'd0);
        chk("arst_mis", 32'(misalign_dm), 32'd0);
        chk("arst_rd", rd_dm, 32'd0);
        chk("arst_state", 32'(dut.state == DM_IDLE), 32'd1);
        req_dm  = 1'b0;
        last_rd = '0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        do_req(1'b0, 32'h20, 32'h0, DM_SZ_W, "ld_after_rst");

        for (int i = 0; i < 250; i++) begin
            logic        we;
            logic [31:0] ad;
            logic [1:0]  sz;
            we = 1'($urandom_range(0, 1));
            ad = 32'($urandom_range(0, NB * 4 - 1));
            sz = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0)
                ad = ad & ~32'(nbytes(sz) - 1);
            do_req(we, ad, $urandom, sz, "rnd");
        end

        repeat (4) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nf_dm_resp.md
# nf_dm_resp

Data-memory responder for the nanoFOX pipeline: the slave end of the MEM-stage load/store handshake. It accepts one request from the MEM stage, inserts a configurable number of wait states, commits or reads the on-chip data RAM, and returns `req_ack_dm`. The hazard unit holds the pipeline stalled until that acknowledge arrives.

## Interface
- `DEPTH`, 1024: RAM size in 32-bit words; must be a power of two.
- `WAIT_CYCLES`, 1: wait states inserted before each access; legal range 0..15.
- `clk`  input  1  system clock; all state changes on its rising edge.
- `resetn`  input  1  reset; asynchronous, active-low.
- `req_dm`  input  1  request valid; held high with stable attributes until `req_ack_dm`.
- `we_dm`  input  1  1 = store, 0 = load.
- `addr_dm`  input  32  byte address.
- `wd_dm`  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- `size_dm`  input  2  0 = byte, 1 = half, 2 = word; 3 is treated as word.
- `rd_dm`  output  32  full 32-bit word at `addr_dm[31:2]`; the CPU selects the lane and sign-extends.
- `req_ack_dm`  output  1  one-cycle completion pulse.
- `misalign_dm`  output  1  pulses with `req_ack_dm` when the access was misaligned.

## Operation
- Three-state FSM:
  - IDLE: if `req_dm` is high, latch addr/wd/we/size, load wait counter with `WAIT_CYCLES`, go to BUSY.
  - BUSY: if counter ≠ 0, decrement it. If counter = 0, perform the RAM access on this edge and go to RESP.
  - RESP: `req_ack_dm` = 1, then go to IDLE unconditionally.
- Word index = latched `addr[$clog2(DEPTH)+1:2]`. Upper address bits are ignored, so accesses alias modulo DEPTH.
- Byte enables from size and `addr[1:0]`:
  - byte: `4'b0001 << addr[1:0]`
  - half: `4'b0011 << {addr[1],1'b0}`
  - word: `4'b1111`
- Store data is lane-shifted: byte by `8*addr[1:0]`, half by `16*addr[1]`.
- Misaligned accesses:
  - Definition: half with `addr[0]=1`, or word with `addr[1:0]≠0`.
  - Store: write is suppressed (all byte enables 0).
  - Load: reads the word normally.
  - Both cases: `misalign_dm` = 1 in RESP.
- `rd_dm` is registered on the access edge and holds until the next load completes. Stores do not change `rd_dm`.
- `req_dm` is sampled only in IDLE. Input changes during BUSY/RESP are ignored because attributes are latched.
- If `req_dm` is high in the IDLE cycle right after RESP, it is a new request and is accepted. Back-to-back requests are legal.

## Timing
- Reset values: state IDLE, counter 0, `req_ack_dm` 0, `misalign_dm` 0, `rd_dm` 0. RAM contents are not reset.
- Latency from the edge that samples `req_dm` in IDLE to `req_ack_dm` high = `WAIT_CYCLES`+1 edges. Measured from the request cycle: ack is asserted `WAIT_CYCLES`+2 cycles after `req_dm` first goes high.
  - `WAIT_CYCLES`=0: ack in cycle 2.
  - `WAIT_CYCLES`=2: ack in cycle 4.
- Throughput: one access per `WAIT_CYCLES`+3 cycles when requests are back-to-back.
- `req_ack_dm` and `misalign_dm` are decoded from the RESP state. They are glitch-free and high for exactly one cycle per request.
- Reset asserted mid-transaction:
  - Immediately returns to IDLE and clears the outputs.
  - A store latched in BUSY that has not reached the access edge is discarded; RAM is unchanged.
- RAM read is synchronous: data is available after the access edge, never combinationally from `addr_dm`.

## Structure
- Package `nf_dm_pkg`:
  - state enum (`DM_IDLE`, `DM_BUSY`, `DM_RESP`)
  - size constants (`DM_SZ_B`, `DM_SZ_H`, `DM_SZ_W`)
  - function returning byte enables and misalign flag from size and `addr[1:0]`
- Sub-module `nf_dm_ram`:
  - single-port, DEPTH×32, per-byte write enables, registered read, no reset on the array.
- `nf_dm_resp` holds the FSM, counter, attribute latches and lane shifter.

## Test plan
- Reset, then idle 5 cycles: `req_ack_dm`=0, `rd_dm`=0, state IDLE throughout.
- `WAIT_CYCLES`=2; store word 0xDEADBEEF to 0x10, then load 0x10: each ack arrives 4 cycles after `req_dm` rises; load returns 0xDEADBEEF.
- Store byte 0xAA to 0x11 and half 0x1234 to 0x12 over word 0x00000000, then load 0x10: `rd_dm`=0x1234AA00.
- Store word 0xFFFFFFFF to 0x12 (misaligned): `misalign_dm`=1 with ack; subsequent load of 0x10 returns the prior value unchanged.
- Back-to-back load 0x0 then load 4×DEPTH (alias): both acks occur, separated by `WAIT_CYCLES`+3 cycles; the second returns the same word as address 0.
- Store to 0x20 with `resetn` pulled low during BUSY: outputs clear asynchronously; after release, load 0x20 returns the pre-store value.
